// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller.
//   - Register offsets relative to BASE_ADDR
//   - Bit position of the valid flag in the VECTOR register
//   - Largest supported channel count (one bit per channel in 8-bit registers)
package irq_ctrl_pkg;

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_VECTOR = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;

  localparam int VEC_VALID_BIT = 7;
  localparam int MAX_N_IRQ     = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source channel: synchroniser chain, previous-sample flop and
// rising-edge detect.
// Ports:
//   clk, reset  - system clock, asynchronous active-low reset
//   raw         - asynchronous flag from the peripheral
//   s           - synchronised flag
//   rise        - high for the cycle where s is 1 and the previous sample was 0
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // prev always tracks s regardless of channel mode, so switching a channel
  // into edge mode never sees a stale sample and cannot fake an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller. Latches N_IRQ peripheral flags (edge or
// level per channel), gates them with per-channel and global enables, and
// presents one fixed-priority request (lowest index wins) to the CPU.
// Ports:
//   clk, reset        - system clock, asynchronous active-low reset
//   address/din/dout  - data bus; dout is registered (valid the cycle after r_en)
//   w_en, r_en        - single-cycle strobes
//   src               - raw interrupt flags
//   src_clr           - one-cycle clear pulse per channel to its peripheral
//   irq, irq_id       - registered request and winning channel id
//   irq_ack           - CPU acknowledge of the current irq_id
//
// Bus handshake: w_en and r_en are single-cycle strobes with no ready/stall;
// every strobe inside the window completes on the clock edge it is sampled,
// and read data appears on dout in the following cycle. Strobes outside the
// window are dropped and dout keeps its value.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int                N_IRQ       = 4,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h1080,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        din,
  input  logic              w_en,
  input  logic              r_en,
  output logic [7:0]        dout,
  input  logic [N_IRQ-1:0]  src,
  output logic [N_IRQ-1:0]  src_clr,
  output logic              irq,
  output logic [2:0]        irq_id,
  input  logic              irq_ack
);

  logic [N_IRQ-1:0]  s, rise;
  logic [N_IRQ-1:0]  pending, enable, mode;
  logic              gie;
  logic [N_IRQ-1:0]  active, w1c, ack_vec, clr_req;
  logic [ADDR_W-1:0] offset_full;
  logic [2:0]        offset;
  logic              hit, wr, rd;
  logic [2:0]        next_id;
  logic [7:0]        rdata;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_chan
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .raw   (src[i]),
      .s     (s[i]),
      .rise  (rise[i])
    );
  end

  // Addresses below the base wrap to large offsets, so one compare covers
  // both ends of the window.
  assign offset_full = address - BASE_ADDR;
  assign hit         = (offset_full <= ADDR_W'(OFF_CTRL));
  assign offset      = offset_full[2:0];
  assign wr          = w_en & hit;
  assign rd          = r_en & hit;

  assign w1c = (wr && offset == OFF_PEND) ? din[N_IRQ-1:0] : '0;

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < N_IRQ; i++)
      ack_vec[i] = irq_ack && irq && (irq_id == 3'(i));
  end

  assign clr_req = w1c | ack_vec;
  assign active  = pending & enable & {N_IRQ{gie}};

  always_comb begin
    next_id = irq_id;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (active[i]) next_id = 3'(i);
  end

  // Reads see the register values before any same-cycle write lands.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_PEND:   rdata = 8'(pending);
      OFF_ENABLE: rdata = 8'(enable);
      OFF_MODE:   rdata = 8'(mode);
      OFF_VECTOR: begin
        rdata[VEC_VALID_BIT] = irq;
        rdata[2:0]           = irq_id;
      end
      OFF_CTRL:   rdata[0] = gie;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      gie     <= 1'b0;
      src_clr <= '0;
      irq     <= 1'b0;
      irq_id  <= '0;
      dout    <= '0;
    end else begin
      // Level channels copy s (this also resolves a 0->1 mode switch: pending
      // keeps s at the switching edge). Edge channels: a new edge beats a clear.
      pending <= (~mode & s) | (mode & (rise | (pending & ~clr_req)));
      // Pulse even for level channels so the peripheral drops its flag.
      src_clr <= clr_req & pending;
      irq     <= |active;
      irq_id  <= next_id;
      if (wr && offset == OFF_ENABLE) enable <= din[N_IRQ-1:0];
      if (wr && offset == OFF_MODE)   mode   <= din[N_IRQ-1:0];
      if (wr && offset == OFF_CTRL)   gie    <= din[0];
      if (rd) dout <= rdata;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller. Inputs change on the falling clock edge
// and outputs are observed on the falling edge, half a period from the
// active rising edge. Every task is entered and left right after a falling
// edge.
module tb_irq_controller;

  localparam int          N_IRQ  = 4;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h1080;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic [7:0]        din;
  logic              w_en, r_en;
  logic [7:0]        dout;
  logic [N_IRQ-1:0]  src, src_clr;
  logic              irq;
  logic [2:0]        irq_id;
  logic              irq_ack;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  irq_controller #(
    .N_IRQ(N_IRQ), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .din(din), .w_en(w_en),
    .r_en(r_en), .dout(dout), .src(src), .src_clr(src_clr), .irq(irq),
    .irq_id(irq_id), .irq_ack(irq_ack)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
    address = addr; din = data; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic read_reg(input logic [15:0] addr, output logic [7:0] data);
    address = addr; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    data = dout;
  endtask

  task automatic read_write_reg(input logic [15:0] addr, input logic [7:0] wdata,
                                output logic [7:0] data);
    address = addr; din = wdata; w_en = 1'b1; r_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    data = dout;
  endtask

  task automatic pulse_src(input logic [N_IRQ-1:0] mask);
    src = mask;
    @(negedge clk);
    src = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; din = '0; w_en = 1'b0; r_en = 1'b0;
    src = '0; irq_ack = 1'b0;
    #3 reset = 1'b0;
    tick(2);
    check("rst_irq", irq, 0);
    check("rst_src_clr", src_clr, 0);
    check("rst_dout", dout, 0);
    reset = 1'b1;
    tick(1);

    // 1: every offset reads zero after reset
    for (int off = 0; off < 5; off++) begin
      read_reg(BASE + 16'(off), rd);
      check($sformatf("rst_reg%0d", off), rd, 8'h00);
    end
    check("rst_irq2", irq, 0);

    // 2: configuration, bit truncation, read-before-write, edge request
    write_reg(BASE + 2, 8'h0F);
    read_write_reg(BASE + 1, 8'hFF, rd);
    check("rw_pre_write", rd, 8'h00);
    read_reg(BASE + 1, rd);
    check("enable_trunc", rd, 8'h0F);
    write_reg(BASE + 4, 8'hFF);
    read_reg(BASE + 4, rd);
    check("ctrl_trunc", rd, 8'h01);
    pulse_src(4'b0100);
    tick(1);
    read_reg(BASE + 0, rd);
    check("pend_early", rd, 8'h00);
    check("irq_early", irq, 0);
    read_reg(BASE + 0, rd);
    check("pend_edge2", rd, 8'h04);
    check("irq_edge2", irq, 1);
    check("id_edge2", irq_id, 2);
    read_reg(BASE + 3, rd);
    check("vector_82", rd, 8'h82);
    read_reg(BASE + 5, rd);
    check("out_of_window_hold", rd, 8'h82);

    // 3: acknowledge and priority
    ack();
    check("clr_ack2", src_clr, 4'b0100);
    tick(1);
    check("clr_ack2_end", src_clr, 0);
    check("irq_after_ack2", irq, 0);
    pulse_src(4'b1010);
    tick(3);
    check("irq_prio", irq, 1);
    check("id_prio", irq_id, 1);
    ack();
    check("clr_ack1", src_clr, 4'b0010);
    check("id_before_update", irq_id, 1);
    read_reg(BASE + 0, rd);
    check("pend_after_ack1", rd, 8'h08);
    check("id_next", irq_id, 3);
    check("clr_ack1_end", src_clr, 0);

    // 4: edge event on the same cycle as a W1C of that channel
    pulse_src(4'b0001);
    tick(1);
    write_reg(BASE + 0, 8'h01);
    tick(1);
    check("irq_set_wins", irq, 1);
    check("id_set_wins", irq_id, 0);
    read_reg(BASE + 0, rd);
    check("pend_set_wins", rd, 8'h09);

    // 5: level mode
    write_reg(BASE + 2, 8'h00);
    src = 4'b0001;
    tick(6);
    check("irq_level", irq, 1);
    check("id_level", irq_id, 0);
    write_reg(BASE + 0, 8'h01);
    check("clr_level", src_clr, 4'b0001);
    read_reg(BASE + 0, rd);
    check("pend_level_w1c", rd, 8'h01);
    check("clr_level_end", src_clr, 0);
    src = '0;
    tick(4);
    check("irq_level_drop", irq, 0);

    // 6: global and per-channel gating, then reset mid-read
    write_reg(BASE + 4, 8'h00);
    src = 4'b0101;
    tick(6);
    check("irq_gie_off", irq, 0);
    read_reg(BASE + 0, rd);
    check("pend_gated", rd, 8'h05);
    write_reg(BASE + 4, 8'h01);
    tick(1);
    check("irq_gie_on", irq, 1);
    check("id_gie_on", irq_id, 0);
    write_reg(BASE + 1, 8'h04);
    tick(1);
    check("id_enable_mask", irq_id, 2);
    read_reg(BASE + 0, rd);
    check("pend_before_rst", rd, 8'h05);
    src = '0;
    address = BASE; r_en = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dout", dout, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_id", irq_id, 0);
    check("mid_rst_clr", src_clr, 0);
    r_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    read_reg(BASE + 0, rd);
    check("pend_after_rst", rd, 8'h00);
    read_reg(BASE + 1, rd);
    check("enable_after_rst", rd, 8'h00);
    check("irq_after_rst", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised, memory-mapped interrupt controller between the SoC peripherals and the CPU interrupt inputs; replaces the fixed four-wire flag/clr interrupt hookup.
- Synchronises N_IRQ source flags and latches them per channel, in edge or level mode.
- Applies per-channel enables and a global enable.
- Presents one prioritised request with its channel id to the CPU, and drives per-source clear pulses back to the peripherals.

Parameters:
N_IRQ, 4, number of interrupt sources (1..8, one bit per channel in every 8-bit register)
ADDR_W, 16, width of the data-bus address
BASE_ADDR, 16'h1080, address of register offset 0; the decode window is BASE_ADDR..BASE_ADDR+4
SYNC_STAGES, 2, flip-flop synchroniser depth on each source input (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
address  in  ADDR_W  data-bus address
din  in  8  write data
w_en  in  1  write strobe (single cycle)
r_en  in  1  read strobe (single cycle)
dout  out  8  read data, registered
src  in  N_IRQ  raw interrupt flags from peripherals
src_clr  out  N_IRQ  one-cycle clear pulse per channel back to its peripheral
irq  out  1  interrupt request to CPU
irq_id  out  3  index of the highest-priority active channel
irq_ack  in  1  CPU acknowledge; clears pending[irq_id]

Behaviour:
Reset:
- While reset is low: all registers, dout, irq, irq_id, src_clr and the synchroniser flops are 0.
- MODE is 0, so every channel is level mode after reset.

Register map (offset from BASE_ADDR):
- 0 PEND: read returns pending bits. Write is write-1-to-clear and applies to edge-mode channels only.
- 1 ENABLE: read/write.
- 2 MODE: read/write; 1 = rising-edge, 0 = level.
- 3 VECTOR: read-only. Bit 7 = irq valid; bits 2:0 = irq_id.
- 4 CTRL: bit 0 is the global interrupt enable (gie); other bits read 0.
- Bits at or above N_IRQ read 0 and ignore writes. Unmapped offsets read 0.
- Writes and reads outside the window are ignored, and dout holds its previous value.

Read path:
- dout is updated on the clock edge where r_en is high and the address hits the window, so data is valid the cycle after r_en (1-cycle latency, matching the data RAM).
- Simultaneous r_en and w_en to the same register: the read returns the pre-write value.

Source path:
- Each source passes through SYNC_STAGES flops, giving s[i].
- Edge channel: pending[i] is set on the clock where s[i] is 1 and the previous s[i] was 0.
- Level channel: pending[i] = s[i] every cycle; W1C and ack have no lasting effect.
- An edge event and a W1C or ack on the same channel in the same cycle: set wins, so pending stays 1.
- Switching MODE from 1 to 0 makes pending follow s[i] from the next cycle.
- Switching MODE from 0 to 1 clears pending[i] only if s[i] is 0. Edge detection uses the stored previous sample, so no spurious edge is generated.

Request path:
- active = pending & ENABLE & {N_IRQ{gie}}.
- Priority is fixed: the lowest index wins.
- irq and irq_id are registered from active, one cycle after pending changes.
- When no channel is active, irq = 0 and irq_id holds its last value.

Acknowledge:
- irq_ack while irq = 1 clears pending[irq_id] (edge channels only).
- irq_ack while irq = 0 is ignored.
- irq_ack and a W1C write in the same cycle: both take effect.

Clear pulses:
- src_clr[i] pulses high for exactly one cycle, the cycle after pending[i] is cleared by W1C or ack.
- The pulse is issued in level mode too, so peripherals drop their flag.
- Multiple bits may pulse together.

Reset mid-operation:
- Takes effect immediately and asynchronously.
- Pending events are lost; no src_clr pulse is emitted.

Decomposition:
- Shared package irq_ctrl_pkg: register offset constants (PEND, ENABLE, MODE, VECTOR, CTRL), VECTOR valid bit position, maximum N_IRQ = 8.
- Sub-module irq_sync_edge: one channel containing the synchroniser, previous-sample flop and rising-edge detect. Instantiated N_IRQ times via generate.

Test Plan:
1. Reset then read each offset 0..4 → all return 0x00; irq = 0, src_clr = 0.
2. Edge mode and request: write MODE = 0x0F, ENABLE = 0x0F, CTRL = 0x01; pulse src[2] high for 1 cycle.
   - Required: pending = 0x04 after SYNC_STAGES+1 cycles; irq = 1, irq_id = 2 one cycle later.
   - Read VECTOR → 0x82.
3. Priority and acknowledge: with src[3] and src[1] edges on the same cycle, irq_id = 1.
   - irq_ack → pending = 0x08, src_clr = 0x02 for one cycle, then irq_id = 3.
4. Set wins: issue a W1C of 0x01 on the same cycle as a new edge on src[0] → pending[0] remains 1 and irq stays 1.
5. Level mode: MODE = 0; hold src[0] high → irq = 1.
   - W1C of 0x01 → pending stays 1 and src_clr[0] pulses.
   - Drop src[0] → irq = 0 within SYNC_STAGES+2 cycles.
6. Enable gating and reset: with CTRL = 0 and pending = 0x05 → irq = 0; set CTRL = 1 → irq = 1, irq_id = 0.
   - Assert reset mid-transfer → all outputs are 0 immediately; after release, pending = 0.
